// File: rtl/rx_deframer.sv
// rx_deframer: serial HDLC/Econet receive deframer.
// Hunts for 0x7E flags, removes stuffed zeros, assembles bytes LSB-first,
// checks CRC-16 (x^16+x^12+x^5+1, init 0xFFFF) against GOOD_RESIDUE and
// streams payload bytes with FCS stripped, plus end-of-frame status.
// Optional build macro RX_STATS_EN adds good_frames/crc_errors/aborts counters.
module rx_deframer #(
    parameter logic [15:0] GOOD_RESIDUE = 16'h1D0F,
    parameter int unsigned MIN_BYTES    = 3
) (
    input  logic        netclk,
    input  logic        reset,
    input  logic        rxdata,
    output logic [7:0]  data_out,
    output logic        data_valid,
    output logic        eop,
    output logic        crc_ok,
    output logic        frame_error,
    output logic        abort,
    output logic        active
`ifdef RX_STATS_EN
    ,
    output logic [15:0] good_frames,
    output logic [15:0] crc_errors,
    output logic [15:0] aborts
`endif
);

    localparam logic [7:0] MIN_CNT = 8'(MIN_BYTES);

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        SYNC  = 2'd1,
        FRAME = 2'd2
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [2:0]  ones;
    logic [2:0]  bitcnt;
    logic [7:0]  shreg;
    logic [7:0]  h1;
    logic [7:0]  h0;
    logic [1:0]  held;
    logic [7:0]  bytecount;
    logic [15:0] crc;
    logic [7:0]  new_byte;
    logic        is_flag;
    logic        is_stuff;
    logic        is_seven;
    logic        data_bit;
    logic        byte_done;
    logic        fe_now;

    // Serial LFSR unrolled over one byte, fed LSB-first.
    function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i] ^ r[15])
                r = {r[14:0], 1'b0} ^ 16'h1021;
            else
                r = {r[14:0], 1'b0};
        end
        return r;
    endfunction

    // State register.
    always_ff @(posedge netclk or posedge reset) begin
        if (reset)
            state <= HUNT;
        else
            state <= next_state;
    end

    // Classify the incoming bit and choose the next state.
    always_comb begin
        is_flag    = !rxdata && (ones == 3'd6);
        is_stuff   = !rxdata && (ones == 3'd5);
        is_seven   = rxdata && (ones == 3'd6);
        data_bit   = (state != HUNT) && !is_flag && !is_stuff && !is_seven;
        byte_done  = data_bit && (bitcnt == 3'd7);
        new_byte   = {rxdata, shreg[7:1]};
        fe_now     = (bytecount < MIN_CNT) || (bitcnt != 3'd7);
        next_state = state;
        case (state)
            HUNT: begin
                if (is_flag)
                    next_state = SYNC;
            end
            SYNC: begin
                if (is_seven)
                    next_state = HUNT;
                else if (byte_done)
                    next_state = FRAME;
            end
            FRAME: begin
                if (is_seven)
                    next_state = HUNT;
                else if (is_flag)
                    next_state = SYNC;
            end
            default: next_state = HUNT;
        endcase
    end

    // Consecutive-ones counter, saturating at 7.
    always_ff @(posedge netclk or posedge reset) begin
        if (reset)
            ones <= '0;
        else if (!rxdata)
            ones <= '0;
        else if (ones != 3'd7)
            ones <= ones + 3'd1;
    end

    // Byte assembly, CRC, two-deep holding pipeline and registered strobes.
    // Two bytes are always held back, so the FCS is still in (h1,h0) when the
    // closing flag arrives and is discarded with the pipeline.
    always_ff @(posedge netclk or posedge reset) begin
        if (reset) begin
            data_out    <= '0;
            data_valid  <= 1'b0;
            eop         <= 1'b0;
            crc_ok      <= 1'b0;
            frame_error <= 1'b0;
            abort       <= 1'b0;
            bitcnt      <= '0;
            shreg       <= '0;
            crc         <= '1;
            h1          <= '0;
            h0          <= '0;
            held        <= '0;
            bytecount   <= '0;
        end else begin
            data_valid  <= 1'b0;
            eop         <= 1'b0;
            crc_ok      <= 1'b0;
            frame_error <= 1'b0;
            abort       <= 1'b0;
            if (state == HUNT) begin
                if (is_flag) begin
                    bitcnt    <= '0;
                    crc       <= '1;
                    held      <= '0;
                    bytecount <= '0;
                end
            end else if (is_seven) begin
                abort <= (state == FRAME);
            end else if (is_flag) begin
                if (state == FRAME) begin
                    eop         <= 1'b1;
                    frame_error <= fe_now;
                    crc_ok      <= !fe_now && (crc == GOOD_RESIDUE);
                end
                bitcnt    <= '0;
                crc       <= '1;
                held      <= '0;
                bytecount <= '0;
            end else if (data_bit) begin
                shreg  <= new_byte;
                bitcnt <= bitcnt + 3'd1;
                if (byte_done) begin
                    crc <= crc_byte(crc, new_byte);
                    if (held == 2'd2) begin
                        data_out   <= h1;
                        data_valid <= 1'b1;
                    end else begin
                        held <= held + 2'd1;
                    end
                    h1 <= h0;
                    h0 <= new_byte;
                    if (bytecount < MIN_CNT)
                        bytecount <= bytecount + 8'd1;
                end
            end
        end
    end

    // Frame-in-progress indicator.
    always_comb begin
        active = (state == FRAME);
    end

`ifdef RX_STATS_EN
    // Frame statistics, counted from the registered end-of-frame and abort strobes.
    always_ff @(posedge netclk or posedge reset) begin
        if (reset) begin
            good_frames <= '0;
            crc_errors  <= '0;
            aborts      <= '0;
        end else begin
            if (eop && crc_ok)
                good_frames <= good_frames + 16'd1;
            if (eop && !crc_ok)
                crc_errors <= crc_errors + 16'd1;
            if (abort)
                aborts <= aborts + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rx_deframer.sv
// tb_rx_deframer: randomized self-checking bench for rx_deframer.
// Frames are described as destuffed bit streams; a frame-level model predicts
// emitted bytes, end-of-frame status and aborts. Honours RX_STATS_EN.
module tb_rx_deframer;

    localparam logic [15:0] GOOD = 16'h1D0F;
    localparam int          MIN  = 3;

    typedef bit         bitq_t[$];
    typedef logic [7:0] byteq_t[$];

    logic        netclk = 1'b0;
    logic        reset;
    logic        rxdata;
    logic [7:0]  data_out;
    logic        data_valid;
    logic        eop;
    logic        crc_ok;
    logic        frame_error;
    logic        abort;
    logic        active;
`ifdef RX_STATS_EN
    logic [15:0] good_frames;
    logic [15:0] crc_errors;
    logic [15:0] aborts;
`endif

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_data[$];
    logic [1:0] exp_eop[$];
    int exp_aborts  = 0;
    int exp_good    = 0;
    int exp_crcerr  = 0;
    int abort_seen  = 0;
    bit in_sync     = 1'b0;

    rx_deframer #(.GOOD_RESIDUE(GOOD), .MIN_BYTES(MIN)) dut (
        .netclk(netclk),
        .reset(reset),
        .rxdata(rxdata),
        .data_out(data_out),
        .data_valid(data_valid),
        .eop(eop),
        .crc_ok(crc_ok),
        .frame_error(frame_error),
        .abort(abort),
        .active(active)
`ifdef RX_STATS_EN
        ,
        .good_frames(good_frames),
        .crc_errors(crc_errors),
        .aborts(aborts)
`endif
    );

    always #5 netclk = ~netclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard: outputs sampled 1 time unit after each active edge.
    always @(posedge netclk) begin
        #1;
        if (data_valid || eop || abort)
            check("strobe_onehot", 32'($countones({data_valid, eop, abort})), 1);
        if (data_valid) begin
            if (exp_data.size() == 0)
                check("data_unexpected", {24'h0, data_out}, 32'hFFFF_FFFF);
            else
                check("data", {24'h0, data_out}, {24'h0, exp_data.pop_front()});
        end
        if (eop) begin
            if (exp_eop.size() == 0)
                check("eop_unexpected", {30'h0, crc_ok, frame_error}, 32'hFFFF_FFFF);
            else
                check("eop_crcok_fe", {30'h0, crc_ok, frame_error}, {30'h0, exp_eop.pop_front()});
        end
        if (abort)
            abort_seen++;
    end

    function automatic bitq_t to_bits(input byteq_t b);
        bitq_t q;
        foreach (b[i])
            for (int j = 0; j < 8; j++)
                q.push_back(b[i][j]);
        return q;
    endfunction

    function automatic logic [15:0] crc_of(input bitq_t e, input int nbits);
        logic [15:0] c;
        bit fb;
        c = 16'hFFFF;
        for (int i = 0; i < nbits; i++) begin
            fb = e[i] ^ c[15];
            c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
        end
        return c;
    endfunction

    // Payload followed by the complemented FCS, high CRC bit transmitted first.
    function automatic byteq_t with_fcs(input byteq_t p);
        byteq_t q;
        logic [15:0] c;
        logic [7:0] f0;
        logic [7:0] f1;
        q = p;
        c = crc_of(to_bits(p), p.size() * 8);
        for (int i = 0; i < 8; i++) begin
            f0[i] = ~c[15 - i];
            f1[i] = ~c[7 - i];
        end
        q.push_back(f0);
        q.push_back(f1);
        return q;
    endfunction

    // Frame-level prediction for destuffed bits d followed by a closing flag.
    task automatic model_frame(input bitq_t d);
        bitq_t e;
        int t;
        int nb;
        logic [7:0] v;
        bit fe;
        bit ok;
        e = d;
        e.push_back(1'b0);
        for (int i = 0; i < 6; i++)
            e.push_back(1'b1);
        t  = e.size();
        nb = t / 8;
        for (int k = 0; k < nb - 2; k++) begin
            for (int j = 0; j < 8; j++)
                v[j] = e[8 * k + j];
            exp_data.push_back(v);
        end
        if (nb >= 1) begin
            fe = (nb < MIN) || (t % 8 != 7);
            ok = !fe && (crc_of(e, 8 * nb) == GOOD);
            exp_eop.push_back({ok, fe});
            if (ok)
                exp_good++;
            else
                exp_crcerr++;
        end
    endtask

    task automatic send_bit(input bit b);
        @(negedge netclk);
        rxdata = b;
    endtask

    task automatic send_ones(input int n);
        for (int i = 0; i < n; i++)
            send_bit(1'b1);
    endtask

    task automatic send_flag();
        send_bit(1'b0);
        send_ones(6);
        send_bit(1'b0);
    endtask

    task automatic send_stuffed(input bitq_t d);
        int run;
        run = 0;
        foreach (d[i]) begin
            send_bit(d[i]);
            run = d[i] ? run + 1 : 0;
            if (run == 5) begin
                send_bit(1'b0);
                run = 0;
            end
        end
    endtask

    task automatic open_frame(input int gap);
        if (gap > 0)
            send_ones(gap);
        if (gap > 0 || !in_sync)
            send_flag();
    endtask

    task automatic send_frame_bits(input bitq_t d, input int gap);
        open_frame(gap);
        model_frame(d);
        send_stuffed(d);
        send_flag();
        in_sync = 1'b1;
    endtask

    // kind: 0 good, 1 corrupted bit, 2 abort after payload, 3 misaligned tail
    task automatic run_frame(input byteq_t payload, input int kind, input int gap);
        bitq_t d;
        byteq_t p;
        int idx;
        int k;
        p = payload;
        k = p.size();
        if (kind == 2) begin
            if (k > 0)
                p[k - 1] = p[k - 1] & 8'h7F;
            d = to_bits(p);
            open_frame(gap);
            for (int i = 0; i < k - 2; i++)
                exp_data.push_back(p[i]);
            if (k >= 1)
                exp_aborts++;
            send_stuffed(d);
            send_ones(8);
            in_sync = 1'b0;
        end else begin
            d = to_bits(with_fcs(p));
            if (kind == 1) begin
                idx = (k > 0) ? int'($urandom_range(0, 8 * k - 1)) : int'($urandom_range(0, 15));
                d[idx] = ~d[idx];
            end else if (kind == 3) begin
                idx = int'($urandom_range(1, 7));
                for (int i = 0; i < idx; i++)
                    d.push_back(1'($urandom));
            end
            send_frame_bits(d, gap);
        end
    endtask

    task automatic check_stats(input string tag);
`ifdef RX_STATS_EN
        check({tag, "_good_frames"}, {16'h0, good_frames}, 32'(exp_good));
        check({tag, "_crc_errors"}, {16'h0, crc_errors}, 32'(exp_crcerr));
        check({tag, "_aborts"}, {16'h0, aborts}, 32'(exp_aborts));
`else
        check({tag, "_aborts_seen"}, 32'(abort_seen), 32'(exp_aborts));
`endif
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_data_out"}, {24'h0, data_out}, 0);
        check({tag, "_outs"}, {26'h0, data_valid, eop, crc_ok, frame_error, abort, active}, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        byteq_t p;
        bitq_t d;
        reset  = 1'b1;
        rxdata = 1'b1;
        repeat (3) @(posedge netclk);
        #1;
        check_all_zero("reset");
        @(negedge netclk);
        reset = 1'b0;
        @(posedge netclk);
        #1;
        check_all_zero("post_reset_idle");

        // 1: basic good frame after idle ones
        p = '{8'h01, 8'h02, 8'h03};
        run_frame(p, 0, 10);
        // 2: payload needing stuffing
        p = '{8'h7E, 8'hFF, 8'h1F};
        run_frame(p, 0, 0);
        // 3: corrupted payload bit
        p = '{8'h01, 8'h02, 8'h03};
        run_frame(p, 1, 9);
        // 4: abort after two bytes, then a good frame
        p = '{8'hA5, 8'h3C};
        d = to_bits(p);
        open_frame(0);
        exp_aborts++;
        send_stuffed(d);
        @(posedge netclk);
        #1;
        check("active_in_frame", {31'h0, active}, 1);
        send_ones(8);
        in_sync = 1'b0;
        @(posedge netclk);
        #1;
        check("active_after_abort", {31'h0, active}, 0);
        p = '{8'h10, 8'h20, 8'h30, 8'h40};
        run_frame(p, 0, 0);
        // 5: runt then repeated flags
        p = '{8'h55};
        d = to_bits(p);
        send_frame_bits(d, 0);
        d = {};
        send_frame_bits(d, 0);
        send_frame_bits(d, 0);
        // 6: twelve data bits then flag
        d = {};
        for (int i = 0; i < 12; i++)
            d.push_back(1'($urandom));
        send_frame_bits(d, 0);

        // randomized frames
        for (int n = 0; n < 40; n++) begin
            p = {};
            for (int i = 0; i < int'($urandom_range(0, 5)); i++)
                p.push_back(8'($urandom));
            run_frame(p, int'($urandom_range(0, 3)), ($urandom_range(0, 1) == 1) ? 0 : int'($urandom_range(7, 12)));
        end
        send_ones(12);
        @(posedge netclk);
        #2;
        check("leftover_data", 32'(exp_data.size()), 0);
        check("leftover_eop", 32'(exp_eop.size()), 0);
        check("abort_count", 32'(abort_seen), 32'(exp_aborts));
        check_stats("run");

        // reset in the middle of a frame
        p = '{8'hC3, 8'h5A};
        d = to_bits(p);
        open_frame(10);
        for (int i = 0; i < 10; i++)
            send_bit(d[i]);
        @(posedge netclk);
        #1;
        check("active_before_reset", {31'h0, active}, 1);
        @(negedge netclk);
        reset = 1'b1;
        #1;
        check_all_zero("midframe_reset");
        @(posedge netclk);
        #1;
        check_all_zero("midframe_reset_edge");
        exp_good   = 0;
        exp_crcerr = 0;
        exp_aborts = 0;
        abort_seen = 0;
        check_stats("after_reset");
        @(negedge netclk);
        reset   = 1'b0;
        in_sync = 1'b0;
        p = '{8'h01, 8'h02, 8'h03};
        run_frame(p, 0, 8);
        send_ones(12);
        @(posedge netclk);
        #2;
        check("final_leftover_data", 32'(exp_data.size()), 0);
        check("final_leftover_eop", 32'(exp_eop.size()), 0);
        check_stats("final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
